cache_req_ctrl: RTL and testbench

- Upstream neighbour of the Cache block: the MEM-stage request controller of the pipelined CPU.
- Converts the stage's level-held mem_read/mem_write request into a single valid/ready transaction to the cache.
- Waits for the cache's completion pulse, then returns load data.
- Drives the pipeline stall while a request is outstanding.
- Keeps hit/miss performance counters.

---
 rtl/cache_req_pkg.sv | 14 +
 rtl/cache_perf_counter.sv | 38 +++
 rtl/cache_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_cache_req_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_pkg.sv
// Shared types and default widths for the MEM-stage cache request controller.
// Optional feature macro: CACHE_PERF_CNT_EN (hit/miss performance counters).
package cache_req_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/cache_perf_counter.sv
// Hit/miss performance counters, bumped once per completed cache transaction.
// Only instantiated when CACHE_PERF_CNT_EN is defined; counters wrap freely.
module cache_perf_counter
    import cache_req_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_done,
    input  logic             i_hit,
    output logic [CNT_W-1:0] o_hit_count,
    output logic [CNT_W-1:0] o_miss_count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_hit;
    logic [CNT_W-1:0] r_miss;

    // Count each completion as exactly one hit or one miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit  <= '0;
            r_miss <= '0;
        end else if (i_done) begin
            if (i_hit) begin
                r_hit <= r_hit + ONE;
            end else begin
                r_miss <= r_miss + ONE;
            end
        end
    end

    assign o_hit_count  = r_hit;
    assign o_miss_count = r_miss;

endmodule

// File: rtl/cache_req_ctrl.sv
// MEM-stage request controller: turns level mem_read/mem_write into one
// valid/ready cache transaction and stalls until completion. Macro: CACHE_PERF_CNT_EN.
module cache_req_ctrl
    import cache_req_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              c_is_ready,
    input  logic              c_is_output_valid,
    input  logic [DATA_W-1:0] c_dout,
    input  logic              c_is_hit,
    output logic              c_is_input_valid,
    output logic [ADDR_W-1:0] c_addr,
    output logic              c_mem_read,
    output logic              c_mem_write,
    output logic [DATA_W-1:0] c_din,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_rd;
    logic              r_wr;
    logic              r_err;

    logic w_req;
    logic w_rd;
    logic w_wr;
    logic w_done;

    assign w_req  = mem_read | mem_write;
    // A simultaneous read+write is issued as a store.
    assign w_wr   = mem_write;
    assign w_rd   = mem_read & ~mem_write;
    assign w_done = ~reset & (r_state == WAIT) & c_is_output_valid;

    // Request FSM: latch the request on accept, return to IDLE on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_din   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (c_is_output_valid) begin
                        r_err <= 1'b1;
                    end
                    if (w_req && c_is_ready) begin
                        r_addr  <= addr;
                        r_din   <= din;
                        r_rd    <= w_rd;
                        r_wr    <= w_wr;
                        r_state <= WAIT;
                        if (mem_read && mem_write) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (c_is_output_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Cache-side and pipeline-side outputs; everything reads 0 while in reset.
    always_comb begin
        c_is_input_valid = 1'b0;
        c_addr           = '0;
        c_din            = '0;
        c_mem_read       = 1'b0;
        c_mem_write      = 1'b0;
        stall            = 1'b0;
        rdata            = '0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    c_is_input_valid = w_req;
                    c_addr           = addr;
                    c_din            = din;
                    c_mem_read       = w_rd;
                    c_mem_write      = w_wr;
                    stall            = w_req;
                end
                WAIT: begin
                    c_addr      = r_addr;
                    c_din       = r_din;
                    c_mem_read  = r_rd;
                    c_mem_write = r_wr;
                    stall       = ~c_is_output_valid;
                    if (c_is_output_valid && r_rd) begin
                        rdata = c_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err = r_err;

`ifdef CACHE_PERF_CNT_EN
    cache_perf_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .i_done      (w_done),
        .i_hit       (c_is_hit),
        .o_hit_count (hit_count),
        .o_miss_count(miss_count)
    );
`else
    logic w_unused;
    assign w_unused   = c_is_hit & w_done;
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl: load/store, slow ready, back-to-back,
// error cases, reset mid-transaction and counter wrap (CNT_W=4).
module tb_cache_req_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] din;
    logic        c_is_ready;
    logic        c_is_output_valid;
    logic [31:0] c_dout;
    logic        c_is_hit;
    logic        c_is_input_valid;
    logic [31:0] c_addr;
    logic        c_mem_read;
    logic        c_mem_write;
    logic [31:0] c_din;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int n_chk;
    int n_pass;
    int n_acc;
    int exp_hit;
    int exp_miss;
    int a0;

    cache_req_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .CNT_W (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .addr             (addr),
        .din              (din),
        .c_is_ready       (c_is_ready),
        .c_is_output_valid(c_is_output_valid),
        .c_dout           (c_dout),
        .c_is_hit         (c_is_hit),
        .c_is_input_valid (c_is_input_valid),
        .c_addr           (c_addr),
        .c_mem_read       (c_mem_read),
        .c_mem_write      (c_mem_write),
        .c_din            (c_din),
        .stall            (stall),
        .rdata            (rdata),
        .err              (err),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && c_is_input_valid && c_is_ready) begin
            n_acc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef CACHE_PERF_CNT_EN
        return 64'(n % 16);
`else
        return 64'(n * 0);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic clr;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        addr              = '0;
        din               = '0;
        c_is_ready        = 1'b0;
        c_is_output_valid = 1'b0;
        c_dout            = '0;
        c_is_hit          = 1'b0;
    endtask

    task automatic do_hit(input logic [31:0] a);
        mem_read   = 1'b1;
        addr       = a;
        c_is_ready = 1'b1;
        tick;
        c_is_ready        = 1'b0;
        c_is_output_valid = 1'b1;
        c_is_hit          = 1'b1;
        c_dout            = a;
        tick;
        clr;
        exp_hit++;
    endtask

    initial begin
        clk = 1'b0;
        n_chk = 0;
        n_pass = 0;
        n_acc = 0;
        exp_hit = 0;
        exp_miss = 0;
        clr;
        reset = 1'b1;
        mem_read = 1'b1;
        addr = 32'h10;
        tick;
        tick;
        mid;
        chk("rst_valid", c_is_input_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_caddr", c_addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        tick;
        reset = 1'b0;
        clr;

        // load hit
        mem_read = 1'b1;
        addr = 32'h100;
        c_is_ready = 1'b1;
        mid;
        chk("lh_valid0", c_is_input_valid, 1);
        chk("lh_stall0", stall, 1);
        chk("lh_caddr", c_addr, 32'h100);
        chk("lh_crd", c_mem_read, 1);
        chk("lh_rdata0", rdata, 0);
        tick;
        c_is_ready = 1'b0;
        c_is_output_valid = 1'b1;
        c_dout = 32'hDEADBEEF;
        c_is_hit = 1'b1;
        mid;
        chk("lh_valid1", c_is_input_valid, 0);
        chk("lh_stall1", stall, 0);
        chk("lh_rdata1", rdata, 32'hDEADBEEF);
        tick;
        clr;
        exp_hit++;
        mid;
        chk("lh_hits", hit_count, exp_cnt(exp_hit));
        chk("lh_stall2", stall, 0);
        chk("lh_rdata2", rdata, 0);

        // store miss, ready late, slow completion
        tick;
        mem_write = 1'b1;
        din = 32'h55;
        addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            mid;
            chk("sm_valid_nr", c_is_input_valid, 1);
            chk("sm_stall_nr", stall, 1);
            tick;
        end
        c_is_ready = 1'b1;
        mid;
        chk("sm_valid_rdy", c_is_input_valid, 1);
        tick;
        c_is_ready = 1'b0;
        addr = 32'hBAD0;
        din = 32'hBAD1;
        for (int i = 0; i < 19; i++) begin
            mid;
            chk("sm_wstall", stall, 1);
            chk("sm_wvalid", c_is_input_valid, 0);
            chk("sm_caddr", c_addr, 32'h200);
            chk("sm_cdin", c_din, 32'h55);
            chk("sm_cwr", c_mem_write, 1);
            tick;
        end
        c_is_output_valid = 1'b1;
        c_is_hit = 1'b0;
        c_dout = 32'hFFFFFFFF;
        mid;
        chk("sm_stall_done", stall, 0);
        chk("sm_rdata", rdata, 0);
        tick;
        clr;
        exp_miss++;
        mid;
        chk("sm_miss", miss_count, exp_cnt(exp_miss));
        chk("sm_hits", hit_count, exp_cnt(exp_hit));

        // back-to-back load then store
        tick;
        a0 = n_acc;
        mem_read = 1'b1;
        addr = 32'h300;
        c_is_ready = 1'b1;
        tick;
        c_is_output_valid = 1'b1;
        c_is_hit = 1'b1;
        c_dout = 32'h1234;
        mid;
        chk("bb_rdata", rdata, 32'h1234);
        tick;
        exp_hit++;
        c_is_output_valid = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b1;
        addr = 32'h304;
        din = 32'h77;
        mid;
        chk("bb_valid2", c_is_input_valid, 1);
        chk("bb_cwr", c_mem_write, 1);
        chk("bb_caddr", c_addr, 32'h304);
        tick;
        c_is_output_valid = 1'b1;
        c_is_hit = 1'b1;
        mid;
        chk("bb_stall", stall, 0);
        tick;
        clr;
        exp_hit++;
        mid;
        chk("bb_acc", 64'(n_acc - a0), 2);
        chk("bb_hits", hit_count, exp_cnt(exp_hit));

        // read and write together: store wins, err set at accept
        tick;
        mem_read = 1'b1;
        mem_write = 1'b1;
        addr = 32'h400;
        din = 32'h99;
        c_is_ready = 1'b1;
        mid;
        chk("bh_cwr0", c_mem_write, 1);
        chk("bh_crd0", c_mem_read, 0);
        chk("bh_err0", err, 0);
        tick;
        c_is_ready = 1'b0;
        c_is_output_valid = 1'b1;
        c_is_hit = 1'b1;
        mid;
        chk("bh_err1", err, 1);
        chk("bh_cwr1", c_mem_write, 1);
        chk("bh_crd1", c_mem_read, 0);
        chk("bh_rdata", rdata, 0);
        tick;
        clr;
        exp_hit++;

        // reset clears err
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        mid;
        chk("rc_err", err, 0);
        chk("rc_hits", hit_count, 0);

        // spurious completion in IDLE
        tick;
        c_is_output_valid = 1'b1;
        c_is_hit = 1'b1;
        c_dout = 32'hAAAA;
        mid;
        chk("sp_stall", stall, 0);
        chk("sp_rdata", rdata, 0);
        tick;
        clr;
        mem_read = 1'b1;
        addr = 32'h500;
        c_is_ready = 1'b1;
        mid;
        chk("sp_err", err, 1);
        chk("sp_valid", c_is_input_valid, 1);
        chk("sp_hits", hit_count, exp_cnt(exp_hit));
        tick;
        c_is_ready = 1'b0;
        mid;
        chk("rm_wstall", stall, 1);
        chk("rm_wvalid", c_is_input_valid, 0);

        // reset while waiting
        tick;
        clr;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mid;
        chk("rm_stall", stall, 0);
        chk("rm_err", err, 0);
        chk("rm_hits", hit_count, 0);
        chk("rm_miss", miss_count, 0);
        tick;
        c_is_output_valid = 1'b1;
        c_is_hit = 1'b1;
        mid;
        chk("rm_pstall", stall, 0);
        tick;
        clr;
        mid;
        chk("rm_perr", err, 1);
        chk("rm_phits", hit_count, 0);

        // counter wrap: 17 hits on a 4-bit counter
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        for (int i = 0; i < 17; i++) begin
            do_hit(32'h1000 + 32'(i * 4));
        end
        mid;
        chk("wr_hits", hit_count, exp_cnt(17));
        chk("wr_miss", miss_count, 0);
        chk("wr_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
